mem_read_ctrl: RTL and testbench
================================

# mem_read_ctrl

Read-side controller for the on-board memory path. It consumes single-cycle pulses from the debounced front-panel buttons (step, reload), walks an address counter through a synchronous-read RAM port, and holds the most recently read word plus its address for the display and LED logic. It is the read counterpart of the load/write control chain and shares the same RAM through a dedicated read port.

## Interface

Parameters:
- ADDR_W, 4: address width; the counter spans 0..2^ADDR_W-1.
- DATA_W, 8: RAM word width.
- RD_LAT, 1: RAM read latency in clocks, counted from the edge that samples mem_en=1 to the edge at which mem_dout is valid. Legal range 1..4.
- SCAN_DIV, 10_000_000: autoscan period in clocks. Used only when MEM_READ_AUTOSCAN_EN is defined.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, asynchronous, active-high.
- step_pulse  in  1  one-cycle pulse; advance the address by one, then read.
- reload_pulse  in  1  one-cycle pulse; re-read the current address.
- scan_en  in  1  autoscan enable. Ignored when the macro is undefined.
- mem_en  out  1  RAM read enable, registered.
- mem_addr  out  ADDR_W  RAM read address, registered.
- mem_dout  in  DATA_W  RAM read data.
- data_out  out  DATA_W  last captured word.
- addr_out  out  ADDR_W  address of data_out.
- data_valid  out  1  data_out is current for addr_out.
- busy  out  1  a read is in flight (state != IDLE).

## Operation

- States: INIT, IDLE, ISSUE, WAIT.
- Reset values: state=INIT, addr=0, mem_en=0, mem_addr=0, data_out=0, addr_out=0, data_valid=0, pend=0, wait counter=0.
- INIT: the first edge after reset release goes to ISSUE for address 0. Reset always produces exactly one automatic read of address 0.
- IDLE:
  - If step_pulse or pend is set: addr <= addr+1, with wrap from 2^ADDR_W-1 to 0. Clear pend. Go to ISSUE.
  - Else if reload_pulse: keep addr. Go to ISSUE.
  - If step and reload arrive on the same edge, step wins and the reload is discarded.
- ISSUE: mem_en=1 and mem_addr=addr for exactly one cycle. data_valid <= 0. Load the wait counter with RD_LAT-1. Go to WAIT.
- WAIT: decrement the counter. When it reaches 0: data_out <= mem_dout, addr_out <= mem_addr, data_valid <= 1. Go to IDLE.
- While busy:
  - A step_pulse sets pend (one deep). Further steps while pend=1 are dropped.
  - reload_pulse is ignored.
- An asynchronous reset in any state, including mid-WAIT, aborts the read and returns all outputs to their reset values. The partial read is never captured.
- The address counter is ADDR_W bits. Wrap is a natural modulo-2^ADDR_W increment.

## Timing

- A step sampled at edge E0 gives mem_en=1 at E0+1. data_out and data_valid update at edge E0+1+RD_LAT. With RD_LAT=1, the latency is 2 clocks.
- Back-to-back reads through the pend flag: the minimum spacing between mem_en pulses is RD_LAT+2 clocks.
- data_valid stays low from the ISSUE cycle until capture. It is never high while data_out is stale relative to mem_addr.
- mem_en is never high for two consecutive cycles.

## Configuration

- MEM_READ_AUTOSCAN_EN defined:
  - A SCAN_DIV prescaler runs while scan_en=1 and generates an internal tick every SCAN_DIV clocks.
  - The tick is ORed with step_pulse and follows the same pend rules.
  - The prescaler clears when scan_en=0 and on reset.
- MEM_READ_AUTOSCAN_EN undefined: no prescaler is built, scan_en is unused, and the block is driven only by step_pulse and reload_pulse.

## Structure

- Shared package mem_rd_pkg holds:
  - the state encodings (INIT=2'b00, IDLE=2'b01, ISSUE=2'b10, WAIT=2'b11);
  - the default ADDR_W, DATA_W and RD_LAT constants;
  - the maximum RD_LAT.
- One sub-module, mem_read_scan_tick: the SCAN_DIV prescaler with enable and synchronous clear. It outputs a one-cycle tick and is instantiated only under the macro.

## Test plan

- Reset, then release. Expect mem_en=1 with mem_addr=0 at the first edge, then data_out=RAM[0], addr_out=0, data_valid=1 after 1+RD_LAT edges, and busy low afterwards.
- With RAM[i]=8'hA0+i, issue 3 spaced step pulses. Expect addr_out=1,2,3, data_out=A1,A2,A3, and each update 2 clocks after its pulse (RD_LAT=1).
- Start at addr=15 with ADDR_W=4 and send a step. Expect mem_addr=0 and data_out=RAM[0]; no out-of-range address appears.
- While busy, send 3 step pulses and 1 reload. Expect exactly one extra read at addr+1, then IDLE with no further mem_en pulses.
- Step and reload on the same edge from addr=5. Expect a single read of address 6.
- Assert rst during WAIT. Expect data_valid=0, data_out=0, and the INIT read of address 0 after release. With the macro, SCAN_DIV=4 and scan_en=1: expect a mem_en pulse every 4 clocks with addresses incrementing.

Source files
------------

// File: rtl/mem_rd_pkg.sv
// mem_rd_pkg: shared definitions for the memory read-side controller.
//   - rd_state_e : controller state encoding
//   - DEF_*      : default parameter values for mem_read_ctrl
//   - MAX_RD_LAT : largest supported RAM read latency
//   - LAT_CNT_W  : width of the read-latency wait counter
package mem_rd_pkg;

    typedef enum logic [1:0] {
        StInit  = 2'b00,
        StIdle  = 2'b01,
        StIssue = 2'b10,
        StWait  = 2'b11
    } rd_state_e;

    localparam int unsigned DEF_ADDR_W = 4;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_RD_LAT = 1;
    localparam int unsigned MAX_RD_LAT = 4;

    // Counter holds RD_LAT-1, so it only needs to reach MAX_RD_LAT-1.
    localparam int unsigned LAT_CNT_W = $clog2(MAX_RD_LAT);

endpackage

// File: rtl/mem_read_scan_tick.sv
// mem_read_scan_tick: autoscan prescaler. Emits a one-cycle tick every DIV clocks
// while enabled; a synchronous clear restarts the count.
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   en   - count enable
//   clr  - synchronous clear (wins over en)
//   tick - one-cycle pulse at the end of each DIV-clock period
module mem_read_scan_tick #(
    parameter int unsigned DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = en & ~clr & (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_read_ctrl.sv
// mem_read_ctrl: read-side controller for the on-board memory path. Front-panel
// step/reload pulses walk an address counter through a synchronous-read RAM port;
// the last word read and its address are held for the display/LED logic.
// Optional build macro: MEM_READ_AUTOSCAN_EN adds a SCAN_DIV prescaler whose tick
// acts as an extra step source while scan_en=1.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   step_pulse    - advance address by one, then read
//   reload_pulse  - re-read the current address
//   scan_en       - autoscan enable (unused without the macro)
//   mem_en        - registered RAM read enable, one cycle per read
//   mem_addr      - registered RAM read address
//   mem_dout      - RAM read data
//   data_out      - last captured word
//   addr_out      - address of data_out
//   data_valid    - data_out is current for addr_out
//   busy          - controller is not idle
module mem_read_ctrl
    import mem_rd_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned RD_LAT   = DEF_RD_LAT,
    parameter int unsigned SCAN_DIV = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_pulse,
    input  logic              reload_pulse,
    input  logic              scan_en,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic              data_valid,
    output logic              busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    rd_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  pend_q, pend_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic [ADDR_W-1:0]     addr_out_q, addr_out_d;
    logic                  valid_q, valid_d;

    logic scan_tick;
    logic step_any;

`ifdef MEM_READ_AUTOSCAN_EN
    mem_read_scan_tick #(
        .DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (scan_en),
        .clr  (~scan_en),
        .tick (scan_tick)
    );
`else
    logic unused_scan;
    assign unused_scan = scan_en ^ (SCAN_DIV == 32'd0);
    assign scan_tick   = 1'b0;
`endif

    assign step_any = step_pulse | scan_tick;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        addr_out_d = addr_out_q;
        valid_d    = valid_q;

        unique case (state_q)
            StInit: begin
                // Automatic read of address 0 after every reset.
                state_d = StIssue;
            end
            StIdle: begin
                if (step_any || pend_q) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    pend_d  = 1'b0;
                    state_d = StIssue;
                end else if (reload_pulse) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = LAT_LOAD;
                state_d = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    data_d     = mem_dout;
                    addr_out_d = mem_addr_q;
                    valid_d    = 1'b1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q - LAT_CNT_W'(1);
                end
            end
        endcase

        // One-deep step queue while a read is in flight; reloads are dropped.
        if (state_q != StIdle && step_any) begin
            pend_d = 1'b1;
        end

        // Output registers are loaded on entry to ISSUE so they are high during it.
        mem_en_d   = (state_d == StIssue);
        mem_addr_d = (state_d == StIssue) ? addr_d : mem_addr_q;
        if (state_d == StIssue) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StInit;
            addr_q     <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            data_q     <= '0;
            addr_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            mem_en_q   <= mem_en_d;
            mem_addr_q <= mem_addr_d;
            data_q     <= data_d;
            addr_out_q <= addr_out_d;
            valid_q    <= valid_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;
    assign data_out   = data_q;
    assign addr_out   = addr_out_q;
    assign data_valid = valid_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Self-checking bench for mem_read_ctrl: table of step/reload vectors plus hand
// sequences for reset, wrap, pend queuing and reset mid-read. Captured words are
// checked against a queue of expected {addr, data} pushed when stimulus is driven.
module tb_mem_read_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RD_LAT = 1;

    logic              clk;
    logic              rst;
    logic              step_pulse;
    logic              reload_pulse;
    logic              scan_en;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] data_out;
    logic [ADDR_W-1:0] addr_out;
    logic              data_valid;
    logic              busy;

    mem_read_ctrl #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .SCAN_DIV (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .step_pulse   (step_pulse),
        .reload_pulse (reload_pulse),
        .scan_en      (scan_en),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_dout     (mem_dout),
        .data_out     (data_out),
        .addr_out     (addr_out),
        .data_valid   (data_valid),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model with RD_LAT clocks of latency.
    logic [DATA_W-1:0] ram [16];
    logic [DATA_W-1:0] pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_en) pipe[0] <= ram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_dout = pipe[RD_LAT-1];

    function automatic logic [DATA_W-1:0] ram_val(input logic [ADDR_W-1:0] a);
        return 8'hA0 + DATA_W'(a);
    endfunction

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } exp_t;

    typedef struct {
        logic              s;
        logic              r;
        logic [ADDR_W-1:0] exp_addr;
    } vec_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   en_cnt   = 0;
    int   b2b_cnt  = 0;
    int   stale_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: scoreboard pops on every capture, plus protocol invariants.
    initial begin
        logic prev_en;
        logic prev_valid;
        exp_t e;
        prev_en    = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_en) en_cnt++;
                if (mem_en && prev_en) b2b_cnt++;
                if (data_valid && addr_out != mem_addr) stale_cnt++;
                if (data_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_capture", {28'd0, addr_out}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_addr", {28'd0, addr_out}, {28'd0, e.a});
                        chk("sb_data", {24'd0, data_out}, {24'd0, e.d});
                    end
                end
            end
            prev_en    = mem_en;
            prev_valid = data_valid;
        end
    end

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            #1;
            if (data_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    // One operation from IDLE: pulse, check the issue cycle, latency and read count.
    task automatic do_op(input logic s, input logic r, input logic [ADDR_W-1:0] exp_addr);
        int en0;
        int lat;
        exp_t e;
        en0 = en_cnt;
        @(negedge clk);
        step_pulse   = s;
        reload_pulse = r;
        e.a = exp_addr;
        e.d = ram_val(exp_addr);
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        step_pulse   = 1'b0;
        reload_pulse = 1'b0;
        chk("issue_en", {31'd0, mem_en}, 32'd1);
        chk("issue_addr", {28'd0, mem_addr}, {28'd0, exp_addr});
        wait_valid(lat);
        chk("op_latency", lat, 1 + RD_LAT);
        chk("op_idle", {31'd0, busy}, 32'd0);
        chk("op_reads", en_cnt - en0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [8];
        int   lat;
        int   en0;
        exp_t e;
`ifdef MEM_READ_AUTOSCAN_EN
        int                hits;
        int                last;
        logic [ADDR_W-1:0] a_exp;
`endif

        for (int i = 0; i < 16; i++) ram[i] = ram_val(ADDR_W'(i));

        vecs[0] = '{s: 1'b1, r: 1'b0, exp_addr: 4'd1};
        vecs[1] = '{s: 1'b1, r: 1'b0, exp_addr: 4'd2};
        vecs[2] = '{s: 1'b1, r: 1'b0, exp_addr: 4'd3};
        vecs[3] = '{s: 1'b0, r: 1'b1, exp_addr: 4'd3};
        vecs[4] = '{s: 1'b1, r: 1'b0, exp_addr: 4'd4};
        vecs[5] = '{s: 1'b1, r: 1'b0, exp_addr: 4'd5};
        vecs[6] = '{s: 1'b1, r: 1'b1, exp_addr: 4'd6};  // step wins over reload
        vecs[7] = '{s: 1'b0, r: 1'b1, exp_addr: 4'd6};

        rst          = 1'b1;
        step_pulse   = 1'b0;
        reload_pulse = 1'b0;
        scan_en      = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_addr_out", {28'd0, addr_out}, 32'd0);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);

        // Automatic INIT read of address 0.
        e.a = 4'd0;
        e.d = ram_val(4'd0);
        exp_q.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("init_en", {31'd0, mem_en}, 32'd1);
        chk("init_addr", {28'd0, mem_addr}, 32'd0);
        wait_valid(lat);
        chk("init_latency", lat, 1 + RD_LAT);
        chk("init_idle", {31'd0, busy}, 32'd0);

        // Table-driven single operations.
        for (int i = 0; i < 8; i++) do_op(vecs[i].s, vecs[i].r, vecs[i].exp_addr);

        // Walk to the top address, then wrap to 0.
        for (int a = 7; a <= 15; a++) do_op(1'b1, 1'b0, ADDR_W'(a));
        chk("top_addr", {28'd0, addr_out}, 32'd15);
        do_op(1'b1, 1'b0, 4'd0);

        // Steps and a reload while busy: exactly one extra read at addr+1.
        en0 = en_cnt;
        @(negedge clk);
        step_pulse = 1'b1;
        e.a = 4'd1;
        e.d = ram_val(4'd1);
        exp_q.push_back(e);
        @(negedge clk);
        step_pulse = 1'b1;                    // ISSUE: sets pend
        e.a = 4'd2;
        e.d = ram_val(4'd2);
        exp_q.push_back(e);
        @(negedge clk);
        step_pulse   = 1'b1;                  // WAIT: pend already set, dropped
        reload_pulse = 1'b1;                  // ignored while busy
        @(negedge clk);
        step_pulse   = 1'b0;
        reload_pulse = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        chk("pend_reads", en_cnt - en0, 2);
        chk("pend_addr", {28'd0, addr_out}, 32'd2);
        chk("pend_idle", {31'd0, busy}, 32'd0);

`ifdef MEM_READ_AUTOSCAN_EN
        // Autoscan: one read every SCAN_DIV=4 clocks, addresses incrementing.
        for (int i = 3; i <= 5; i++) begin
            e.a = ADDR_W'(i);
            e.d = ram_val(ADDR_W'(i));
            exp_q.push_back(e);
        end
        hits  = 0;
        last  = 0;
        a_exp = 4'd3;
        @(negedge clk);
        scan_en = 1'b1;
        for (int c = 0; c < 40 && hits < 3; c++) begin
            @(negedge clk);
            #1;
            if (mem_en) begin
                chk("scan_addr", {28'd0, mem_addr}, {28'd0, a_exp});
                if (hits > 0) chk("scan_period", c - last, 4);
                a_exp = a_exp + 4'd1;
                last  = c;
                hits++;
            end
        end
        scan_en = 1'b0;
        chk("scan_hits", hits, 3);
        repeat (10) @(negedge clk);
`endif

        // Reset during WAIT aborts the read; nothing partial is captured.
        @(negedge clk);
        step_pulse = 1'b1;
        @(negedge clk);
        #1;
        step_pulse = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, data_valid}, 32'd0);
        chk("abort_data", {24'd0, data_out}, 32'd0);
        chk("abort_addr_out", {28'd0, addr_out}, 32'd0);
        chk("abort_mem_en", {31'd0, mem_en}, 32'd0);
        chk("abort_mem_addr", {28'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        e.a = 4'd0;
        e.d = ram_val(4'd0);
        exp_q.push_back(e);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reinit_addr", {28'd0, mem_addr}, 32'd0);
        wait_valid(lat);
        chk("reinit_latency", lat, 1 + RD_LAT);
        repeat (5) @(negedge clk);

        chk("sb_drained", exp_q.size(), 0);
        chk("no_b2b_mem_en", b2b_cnt, 0);
        chk("no_stale_valid", stale_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
